constraint_sample_sequencer: RTL and testbench
==============================================

// Module: constraint_sample_sequencer
// PURPOSE
//   Drives candidate input vectors into an external combinational constraint checker and
//   collects the vectors that satisfy it. Candidates come from an internal Galois LFSR.
//   The checker's single satisfy bit returns CHK_LAT cycles later; the block counts retries
//   per sample and hands accepted vectors out over a valid/ready stream.
//   Sits between the stimulus test harness and a generated constraint block.
// PARAMETERS
//   VEC_W      64                    candidate width; concatenation of all checker inputs
//   POLY       64'hD800000000000000  Galois feedback taps, 64,63,61,60
//   SEED       64'h1                 LFSR reset value; 0 is replaced by 1
//   CHK_LAT    1                     cycles from cand_o change to valid sat_i; range 1..15
//   MAX_TRIES  1024                  rejected candidates allowed per sample before failure
//   CNT_W      16                    width of num_samples_i and the counters
// PORTS
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   start_i        in   1      run request; sampled only in IDLE
//   num_samples_i  in   CNT_W  samples to collect; latched on start
//   seed_load_i    in   1      load seed_i into the LFSR; honoured only in IDLE
//   seed_i         in   VEC_W  new seed
//   cand_o         out  VEC_W  candidate driven to the checker
//   sat_i          in   1      checker result (x) for cand_o
//   smp_valid_o    out  1      accepted sample available
//   smp_ready_i    in   1      consumer ready
//   smp_data_o     out  VEC_W  accepted sample
//   busy_o         out  1      high in GEN, WAIT and OUT
//   done_o         out  1      one-cycle pulse when a run completes
//   fail_o         out  1      sticky; MAX_TRIES reached; cleared by the next accepted start
//   tries_o        out  CNT_W  rejects counted against the current sample
// BEHAVIOUR
//   Reset values: all outputs 0; LFSR = SEED, or 1 if SEED==0; FSM in IDLE.
//   FSM states: IDLE, GEN, WAIT, OUT, FAIL.
//   IDLE
//     - seed_load_i loads the LFSR; seed_i==0 loads 1.
//     - If seed_load_i and start_i arrive together, the seed loads first and the run starts.
//     - start_i with num_samples_i!=0: latch the count, clear tries_o and fail_o, go to GEN.
//     - start_i with num_samples_i==0: pulse done_o, stay in IDLE.
//   GEN (1 cycle)
//     - Step the LFSR once; cand_o <= new LFSR value.
//     - Load the wait counter with CHK_LAT; go to WAIT.
//   WAIT (CHK_LAT cycles)
//     - sat_i is sampled on the last WAIT cycle only.
//     - sat_i=1: smp_data_o <= cand_o, smp_valid_o <= 1, go to OUT.
//     - sat_i=0: tries_o+1. If the new value == MAX_TRIES, go to FAIL; otherwise go to GEN.
//   OUT
//     - smp_valid_o, smp_data_o and the LFSR are held stable until smp_ready_i is high.
//     - On handshake: remaining-1, tries_o <= 0, smp_valid_o <= 0.
//     - If remaining reaches 0: pulse done_o, go to IDLE. Otherwise go to GEN.
//   FAIL (1 cycle)
//     - fail_o <= 1; go to IDLE. No done_o pulse.
//   Timing and arithmetic
//     - Samples accepted on the first try arrive every CHK_LAT+2 cycles when ready is held high.
//     - Latency from start_i to the first cand_o update is 2 cycles.
//     - cand_o keeps its last value outside GEN.
//     - Counters wrap modulo 2^CNT_W; MAX_TRIES must be < 2^CNT_W.
//   Other rules
//     - start_i and seed_load_i are ignored while busy_o is high.
//     - rst_n low mid-run aborts immediately: outputs return to reset values; nothing is emitted.
// CONFIGURATION
//   SAMPLER_STATS_EN defined
//     - Adds output rej_total_o [31:0]: rejects summed across all runs. Saturates at 32'hFFFFFFFF.
//     - Cleared only by reset.
//     - Adds output acc_total_o [31:0]: accepted handshakes, same rules.
//   SAMPLER_STATS_EN undefined
//     - Neither port nor counter exists; all other behaviour is identical.
// TESTING
//   1 Reset: rst_n low with clk toggling -> all outputs 0. Release; sat_i=1, num=1
//     -> first cand_o = step(SEED).
//   2 Throughput: sat_i=1, smp_ready_i=1, num=3, CHK_LAT=1 -> 3 handshakes 3 cycles apart.
//     smp_data_o = step^1, step^2, step^3 of SEED; done_o pulses once; tries_o stays 0.
//   3 Failure: sat_i=0, MAX_TRIES=8, num=2 -> exactly 8 GEN cycles, then fail_o=1, tries_o=8.
//     No smp_valid_o, no done_o. The next start clears fail_o.
//   4 Backpressure: sat_i=1, smp_ready_i low for 5 cycles -> smp_valid_o held 5+ cycles.
//     smp_data_o and cand_o stable; the next candidate is step of the held value.
//   5 Seed: seed_load_i=1 with seed_i=0 in IDLE, then run num=1 with sat_i=1 -> sample = step(1).
//     seed_load_i while busy -> sequence unchanged.
//   6 Abort and stats: rst_n asserted in WAIT with CHK_LAT=3 -> IDLE, outputs 0.
//     With SAMPLER_STATS_EN: 5 rejects then 1 accept -> rej_total_o=5, acc_total_o=1.

Source files
------------

// File: rtl/constraint_sample_sequencer.sv
// constraint_sample_sequencer
//   Generates candidate vectors with a Galois LFSR, presents each one to an
//   external combinational constraint checker and collects the candidates the
//   checker accepts. Accepted vectors leave through a valid/ready stream.
//   Rejects are counted per sample. After MAX_TRIES rejects the run is
//   abandoned and the sticky fail flag is raised.
//   Optional feature macro: SAMPLER_STATS_EN. When it is defined, the block
//   adds lifetime reject/accept totals (rej_total_o, acc_total_o).
module constraint_sample_sequencer #(
  parameter int                 VEC_W     = 64,
  parameter logic [VEC_W-1:0]   POLY      = 64'hD800000000000000,
  parameter logic [VEC_W-1:0]   SEED      = 64'h1,
  parameter int                 CHK_LAT   = 1,
  parameter int                 MAX_TRIES = 1024,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_samples_i,
  input  logic             seed_load_i,
  input  logic [VEC_W-1:0] seed_i,
  output logic [VEC_W-1:0] cand_o,
  input  logic             sat_i,
  output logic             smp_valid_o,
  input  logic             smp_ready_i,
  output logic [VEC_W-1:0] smp_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] tries_o
`ifdef SAMPLER_STATS_EN
  ,
  output logic [31:0]      rej_total_o,
  output logic [31:0]      acc_total_o
`endif
);

  // A zero LFSR state would lock up, so a zero seed is replaced by 1.
  localparam logic [VEC_W-1:0] ONE_VEC  = {{(VEC_W-1){1'b0}}, 1'b1};
  localparam logic [VEC_W-1:0] SEED_EFF = (SEED == '0) ? ONE_VEC : SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_WAIT,
    S_OUT,
    S_FAIL
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [VEC_W-1:0] lfsr;
  logic [VEC_W-1:0] lfsr_step;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] tries_inc;
  logic [3:0]       wait_cnt;
  logic             wait_last;
  logic             handshake;

  // The feedback bit is the outgoing LSB. It is XORed into every tap position
  // of the right-shifted state.
  genvar gi;
  generate
    for (gi = 0; gi < VEC_W - 1; gi++) begin : g_lfsr
      assign lfsr_step[gi] = lfsr[gi+1] ^ (POLY[gi] & lfsr[0]);
    end
  endgenerate
  assign lfsr_step[VEC_W-1] = POLY[VEC_W-1] & lfsr[0];

  assign tries_inc = tries_o + 1'b1;
  assign wait_last = (wait_cnt == 4'd1);
  assign handshake = (state == S_OUT) && smp_ready_i;
  assign busy_o    = (state == S_GEN) || (state == S_WAIT) || (state == S_OUT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode. The checker result is used only on the last WAIT cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_i && (num_samples_i != '0)) state_next = S_GEN;
      S_GEN:  state_next = S_WAIT;
      S_WAIT: begin
        if (wait_last) begin
          if (sat_i)                                state_next = S_OUT;
          else if (tries_inc == CNT_W'(MAX_TRIES))  state_next = S_FAIL;
          else                                      state_next = S_GEN;
        end
      end
      S_OUT: begin
        if (smp_ready_i) state_next = (remaining == CNT_W'(1)) ? S_IDLE : S_GEN;
      end
      S_FAIL: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: LFSR, candidate, sample register, counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= SEED_EFF;
      cand_o      <= '0;
      smp_valid_o <= 1'b0;
      smp_data_o  <= '0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      tries_o     <= '0;
      remaining   <= '0;
      wait_cnt    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (seed_load_i) lfsr <= (seed_i == '0) ? ONE_VEC : seed_i;
          if (start_i) begin
            if (num_samples_i != '0) begin
              remaining <= num_samples_i;
              tries_o   <= '0;
              fail_o    <= 1'b0;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        S_GEN: begin
          lfsr     <= lfsr_step;
          cand_o   <= lfsr_step;
          wait_cnt <= 4'(CHK_LAT);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_last) begin
            if (sat_i) begin
              smp_data_o  <= cand_o;
              smp_valid_o <= 1'b1;
            end else begin
              tries_o <= tries_inc;
            end
          end
        end
        S_OUT: begin
          if (smp_ready_i) begin
            remaining   <= remaining - 1'b1;
            tries_o     <= '0;
            smp_valid_o <= 1'b0;
            if (remaining == CNT_W'(1)) done_o <= 1'b1;
          end
        end
        S_FAIL: fail_o <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SAMPLER_STATS_EN
  logic reject_evt;
  assign reject_evt = (state == S_WAIT) && wait_last && !sat_i;

  // Lifetime totals that saturate instead of wrapping. Only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_total_o <= '0;
      acc_total_o <= '0;
    end else begin
      if (reject_evt && (rej_total_o != 32'hFFFFFFFF)) rej_total_o <= rej_total_o + 32'd1;
      if (handshake && (acc_total_o != 32'hFFFFFFFF))  acc_total_o <= acc_total_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_constraint_sample_sequencer.sv
// Testbench for constraint_sample_sequencer. A behavioural model predicts the
// accepted samples, reject counts and run outcome from the LFSR recurrence and
// the checker predicate. The predicate is driven combinationally from cand_o.
module tb_constraint_sample_sequencer;

  localparam int          LAT  = 3;
  localparam int          MAXT = 8;
  localparam logic [63:0] POLY = 64'hD800000000000000;
  localparam logic [63:0] SEED = 64'h1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        seed_load;
  logic [63:0] seed;
  logic [63:0] cand;
  logic        sat;
  logic        smp_valid;
  logic        smp_ready;
  logic [63:0] smp_data;
  logic        busy;
  logic        done;
  logic        fail;
  logic [15:0] tries;
`ifdef SAMPLER_STATS_EN
  logic [31:0] rej_total;
  logic [31:0] acc_total;
`endif

  constraint_sample_sequencer #(
    .VEC_W(64), .POLY(POLY), .SEED(SEED), .CHK_LAT(LAT), .MAX_TRIES(MAXT), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .num_samples_i(num_samples),
    .seed_load_i(seed_load), .seed_i(seed), .cand_o(cand), .sat_i(sat),
    .smp_valid_o(smp_valid), .smp_ready_i(smp_ready), .smp_data_o(smp_data),
    .busy_o(busy), .done_o(done), .fail_o(fail), .tries_o(tries)
`ifdef SAMPLER_STATS_EN
    , .rej_total_o(rej_total), .acc_total_o(acc_total)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Checker configuration: 0 = always reject, 1 = always accept, 2 = parity of masked bits.
  int          sat_mode  = 1;
  logic [63:0] sat_mask  = '0;
  int          ready_mode = 1; // 0 = low, 1 = high, 2 = random

  logic [63:0] model_lfsr = SEED;
  int unsigned model_rej  = 0;
  int unsigned model_acc  = 0;

  logic [63:0] got_q[$];
  int          hs_cyc_q[$];
  int          cyc      = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  function automatic logic pred(input logic [63:0] c, input int mode, input logic [63:0] mask);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ^(c & mask);
  endfunction

  always_comb sat = pred(cand, sat_mode, sat_mask);

  // Ready driver, updated just after each rising edge.
  initial begin
    smp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       smp_ready = 1'b0;
        1:       smp_ready = 1'b1;
        default: smp_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor on the falling edge: a valid&ready seen here completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && smp_valid && smp_ready) begin
        got_q.push_back(smp_data);
        hs_cyc_q.push_back(cyc);
      end
      if (rst_n && done) done_cnt++;
    end
  end

  task automatic check_stats();
`ifdef SAMPLER_STATS_EN
    check("rej_total", 64'(rej_total), 64'(model_rej));
    check("acc_total", 64'(acc_total), 64'(model_acc));
`endif
  endtask

  // Runs one start request and compares the result against the model.
  task automatic run(input int num, input int mode, input logic [63:0] mask,
                     input bit ld_with_start, input logic [63:0] ld_val, input bit ld_busy);
    logic [63:0] exp_q[$];
    logic [63:0] lf;
    bit          exp_fail;
    int          t;
    int          d0;
    int          n;
    bit          got_one;

    if (ld_with_start) model_lfsr = (ld_val == '0) ? 64'h1 : ld_val;
    lf       = model_lfsr;
    exp_fail = 1'b0;
    for (int s = 0; s < num && !exp_fail; s++) begin
      t       = 0;
      got_one = 1'b0;
      while (!got_one && !exp_fail) begin
        lf = step(lf);
        if (pred(lf, mode, mask)) begin
          exp_q.push_back(lf);
          got_one = 1'b1;
          model_acc++;
        end else begin
          t++;
          model_rej++;
          if (t == MAXT) exp_fail = 1'b1;
        end
      end
    end

    sat_mode = mode;
    sat_mask = mask;
    got_q.delete();
    hs_cyc_q.delete();
    d0 = done_cnt;

    @(posedge clk);
    #1;
    start       = 1'b1;
    num_samples = 16'(num);
    seed_load   = ld_with_start;
    seed        = ld_val;
    @(posedge clk);
    #1;
    start     = 1'b0;
    seed_load = 1'b0;
    if (num > 0) begin
      @(posedge clk);
      #1;
      check("cand_latency", cand, step(model_lfsr));
      if (ld_busy) begin
        seed_load = 1'b1;
        seed      = {$urandom, $urandom};
        @(posedge clk);
        #1;
        seed_load = 1'b0;
      end
    end
    model_lfsr = lf;

    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("run_timeout", 64'(n >= 5000), 64'd0);
    repeat (2) @(negedge clk);

    $display("run num=%0d mode=%0d samples=%0d exp=%0d fail=%0b", num, mode, got_q.size(), exp_q.size(), fail);
    check("sample_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("sample_%0d", i), got_q[i], exp_q[i]);
    check("fail_flag", 64'(fail), 64'(exp_fail));
    check("tries", 64'(tries), exp_fail ? 64'(MAXT) : 64'd0);
    check("done_pulses", 64'(done_cnt - d0), exp_fail ? 64'd0 : 64'd1);
    check("busy_idle", 64'(busy), 64'd0);
    check_stats();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cand"},  cand, 64'd0);
    check({tag, "_valid"}, 64'(smp_valid), 64'd0);
    check({tag, "_data"},  smp_data, 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_fail"},  64'(fail), 64'd0);
    check({tag, "_tries"}, 64'(tries), 64'd0);
  endtask

  initial begin
    logic [63:0] held_d;
    logic [63:0] held_c;
    logic [63:0] s1;
    logic [63:0] s2;
    int          n;

    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    seed_load   = 1'b0;
    seed        = '0;

    // Reset state with the clock running.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check_stats();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First sample after reset is one step of SEED.
    ready_mode = 1;
    run(1, 1, '0, 1'b0, '0, 1'b0);

    // Throughput: first-try accepts arrive every LAT+2 cycles.
    run(3, 1, '0, 1'b0, '0, 1'b0);
    for (int i = 1; i < hs_cyc_q.size(); i++)
      check("throughput_gap", 64'(hs_cyc_q[i] - hs_cyc_q[i-1]), 64'(LAT + 2));

    // Failure after MAX_TRIES rejects, then a passing run clears fail.
    run(2, 0, '0, 1'b0, '0, 1'b0);
    run(1, 1, '0, 1'b0, '0, 1'b0);

    // Backpressure: sample, candidate and LFSR hold while ready is low.
    ready_mode = 0;
    sat_mode   = 1;
    s1 = step(model_lfsr);
    s2 = step(s1);
    got_q.delete();
    @(posedge clk);
    #1;
    start       = 1'b1;
    num_samples = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!smp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_timeout", 64'(n >= 100), 64'd0);
    held_d = smp_data;
    held_c = cand;
    check("bp_first", held_d, s1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(smp_valid), 64'd1);
      check("bp_data_held", smp_data, held_d);
      check("bp_cand_held", cand, held_c);
    end
    ready_mode = 1;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    $display("backpressure samples=%0d", got_q.size());
    check("bp_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) check("bp_second", got_q[1], s2);
    model_lfsr = s2;
    model_acc += 2;
    check_stats();

    // Zero seed in IDLE loads 1.
    @(posedge clk);
    #1;
    seed_load = 1'b1;
    seed      = '0;
    @(posedge clk);
    #1;
    seed_load  = 1'b0;
    model_lfsr = 64'h1;
    run(1, 1, '0, 1'b0, '0, 1'b0);
    // Seed loaded together with start, and a seed load while busy that must be ignored.
    run(2, 1, '0, 1'b1, 64'hDEADBEEF_12345678, 1'b1);
    run(0, 1, '0, 1'b0, '0, 1'b0);

    // Randomized runs with a parity predicate and random ready.
    ready_mode = 2;
    for (int r = 0; r < 12; r++)
      run($urandom_range(0, 4), ($urandom_range(0, 9) == 0) ? 0 : 2, {$urandom, $urandom},
          1'($urandom % 3 == 0), {$urandom, $urandom}, 1'($urandom % 2));

    // Abort in WAIT: reset returns every output to zero at once.
    ready_mode = 1;
    sat_mode   = 0;
    @(posedge clk);
    #1;
    start       = 1'b1;
    num_samples = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort_in_wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    model_lfsr = SEED;
    model_rej  = 0;
    model_acc  = 0;
    check_stats();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // After the abort the sequence restarts from SEED.
    run(2, 2, 64'h0F0F_0000_00F0_1234, 1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
